// File: rtl/mvb_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : mvb_frame_deserializer
// Purpose  : MVB serial-to-word deserializer with per-block CRC7+parity check
//            stripping and frame-level ok/abort status, 3 MHz bit domain.
// Revision : 1.0  initial release
// ============================================================================
module mvb_frame_deserializer #(
    parameter int         WORD_W     = 16,
    parameter int         BLOCK_BITS = 64,
    parameter int         MAX_BLOCKS = 4,
    parameter logic [6:0] CRC_POLY   = 7'h65,
    parameter int         IDX_W      = 5
) (
    input  logic              clk_3M,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              bit_valid,
    input  logic              data_in,
    input  logic              quality_error,
    input  logic [2:0]        frame_len_sel,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic [IDX_W-1:0]  word_index,
    output logic              block_done,
    output logic              crc_error,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              frame_abort,
    output logic              busy
);

    localparam int                 c_LEN_W    = 10;
    localparam int                 c_WCNT_W   = $clog2(WORD_W + 1);
    localparam logic [c_LEN_W-1:0] c_BLK_BITS = c_LEN_W'(BLOCK_BITS);
    localparam logic [c_LEN_W-1:0] c_MAX_BITS = c_LEN_W'(MAX_BLOCKS * BLOCK_BITS);
    localparam logic [c_WCNT_W-1:0] c_WORD_W  = c_WCNT_W'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_LEN_W-1:0]   r_data_left;
    logic [c_LEN_W-1:0]   r_blk_left;
    logic [c_WCNT_W-1:0]  r_wcnt;
    logic [IDX_W-1:0]     r_word_cnt;
    logic [6:0]           r_crc;
    logic                 r_par;
    logic [6:0]           r_chk;
    logic [2:0]           r_chk_cnt;
    logic                 r_frame_err;

    logic                 w_busy, w_go, w_sel_ok, w_qerr, w_start, w_abort;
    logic                 w_data_bit, w_chk_bit, w_blk_last, w_chk_last, w_more;
    logic [c_LEN_W-1:0]   w_sel_bits, w_first_blk, w_next_blk;
    logic [c_LEN_W-1:0]   w_data_left_cur, w_blk_left_cur;
    logic [6:0]           w_crc_base, w_crc_next;
    logic                 w_par_base, w_fb, w_mismatch;
    logic [7:0]           w_calc_chk, w_rx_chk;
    logic [c_WCNT_W-1:0]  w_wcnt_next;
    logic                 w_word_done;
    logic [IDX_W-1:0]     w_widx_base;
    logic [WORD_W-1:0]    w_word_next;

    always_comb begin
        w_busy          = (r_state != S_IDLE);
        w_go            = frame_start & bit_valid;
        w_sel_bits      = c_LEN_W'(16) << frame_len_sel;
        w_sel_ok        = (frame_len_sel <= 3'd4) && (w_sel_bits <= c_MAX_BITS);
        w_qerr          = bit_valid & quality_error & w_busy;
        w_start         = w_go & w_sel_ok & ~w_qerr;
        w_abort         = w_qerr | (w_go & (w_busy | ~w_sel_ok));
        w_data_bit      = w_start | ((r_state == S_DATA) & bit_valid & ~w_go & ~w_qerr);
        w_chk_bit       = (r_state == S_CHECK) & bit_valid & ~w_go & ~w_qerr;
        w_first_blk     = (w_sel_bits > c_BLK_BITS) ? c_BLK_BITS : w_sel_bits;
        w_next_blk      = (r_data_left > c_BLK_BITS) ? c_BLK_BITS : r_data_left;
        w_data_left_cur = w_start ? w_sel_bits : r_data_left;
        w_blk_left_cur  = w_start ? w_first_blk : r_blk_left;
        w_blk_last      = (w_blk_left_cur == c_LEN_W'(1));
        w_chk_last      = w_chk_bit & (r_chk_cnt == 3'd7);
        w_more          = (r_data_left != '0);

        // MSB-first LFSR; a new frame restarts the check from zero on bit 0
        w_crc_base      = w_start ? 7'd0 : r_crc;
        w_par_base      = w_start ? 1'b0 : r_par;
        w_fb            = data_in ^ w_crc_base[6];
        w_crc_next      = {w_crc_base[5:0], 1'b0} ^ (w_fb ? CRC_POLY : 7'd0);
        w_calc_chk      = {r_crc, (^r_crc) ^ r_par};
        w_rx_chk        = {r_chk, data_in};
        w_mismatch      = (w_calc_chk != w_rx_chk);

        w_wcnt_next     = (w_start ? '0 : r_wcnt) + c_WCNT_W'(1);
        w_word_done     = w_data_bit & (w_wcnt_next == c_WORD_W);
        w_widx_base     = w_start ? '0 : r_word_cnt;
    end

    generate
        if (WORD_W == 1) begin : g_word_bitwise
            assign w_word_next = data_in;
        end else begin : g_word_shift
            logic [WORD_W-2:0] r_part;
            always_ff @(posedge clk_3M or negedge rst) begin
                if (!rst)
                    r_part <= '0;
                else if (w_data_bit)
                    r_part <= w_word_next[WORD_W-2:0];
            end
            assign w_word_next = {r_part, data_in};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        if (w_data_bit)
            w_state_next = w_blk_last ? S_CHECK : S_DATA;
        else if (w_abort)
            w_state_next = S_IDLE;
        else if (w_chk_last)
            w_state_next = w_more ? S_DATA : S_IDLE;
    end

    always_ff @(posedge clk_3M or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk_3M or negedge rst) begin
        if (!rst) begin
            r_data_left <= '0;
            r_blk_left  <= '0;
            r_wcnt      <= '0;
            r_word_cnt  <= '0;
            r_crc       <= '0;
            r_par       <= 1'b0;
            r_chk       <= '0;
            r_chk_cnt   <= '0;
            r_frame_err <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            word_index  <= '0;
            block_done  <= 1'b0;
            crc_error   <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            block_done  <= 1'b0;
            crc_error   <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_abort <= w_abort;

            if (w_start) begin
                r_frame_err <= 1'b0;
                r_chk_cnt   <= '0;
                word_index  <= '0;
            end

            if (w_data_bit) begin
                r_data_left <= w_data_left_cur - c_LEN_W'(1);
                r_blk_left  <= w_blk_left_cur - c_LEN_W'(1);
                r_crc       <= w_crc_next;
                r_par       <= w_par_base ^ data_in;
                if (w_word_done) begin
                    r_wcnt     <= '0;
                    word_data  <= w_word_next;
                    word_valid <= 1'b1;
                    word_index <= w_widx_base;
                    r_word_cnt <= w_widx_base + IDX_W'(1);
                end else begin
                    r_wcnt     <= w_wcnt_next;
                    r_word_cnt <= w_widx_base;
                end
            end

            if (w_chk_bit) begin
                r_chk     <= w_rx_chk[6:0];
                r_chk_cnt <= r_chk_cnt + 3'd1;
            end

            // Verdict for the block; the next block restarts the check from zero
            if (w_chk_last) begin
                block_done  <= 1'b1;
                crc_error   <= w_mismatch;
                r_frame_err <= r_frame_err | w_mismatch;
                r_crc       <= '0;
                r_par       <= 1'b0;
                r_blk_left  <= w_next_blk;
                if (!w_more) begin
                    frame_done <= 1'b1;
                    frame_ok   <= ~(r_frame_err | w_mismatch);
                end
            end
        end
    end

    assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mvb_frame_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mvb_frame_deserializer
// Purpose  : Directed + randomized bench with a polynomial-division reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_mvb_frame_deserializer;

    logic        clk_3M = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0, bit_valid = 1'b0, data_in = 1'b0, quality_error = 1'b0;
    logic [2:0]  frame_len_sel = 3'd0;
    logic [15:0] word_data;
    logic        word_valid, block_done, crc_error, frame_done, frame_ok, frame_abort, busy;
    logic [4:0]  word_index;

    mvb_frame_deserializer dut (
        .clk_3M(clk_3M), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
        .data_in(data_in), .quality_error(quality_error), .frame_len_sel(frame_len_sel),
        .word_data(word_data), .word_valid(word_valid), .word_index(word_index),
        .block_done(block_done), .crc_error(crc_error), .frame_done(frame_done),
        .frame_ok(frame_ok), .frame_abort(frame_abort), .busy(busy)
    );

    always #5 clk_3M = ~clk_3M;

    int cyc = 0;
    always @(posedge clk_3M) cyc <= cyc + 1;

    // Observed events
    logic [31:0] mon_words[$];
    logic        mon_blk[$];
    logic        mon_frm[$];
    int          mon_abort, fd_cyc, ab_cyc;

    always @(negedge clk_3M) begin
        if (rst) begin
            if (word_valid)  mon_words.push_back({11'd0, word_index, word_data});
            if (block_done)  mon_blk.push_back(crc_error);
            if (frame_done)  begin mon_frm.push_back(frame_ok); fd_cyc = cyc; end
            if (frame_abort) begin mon_abort++; ab_cyc = cyc; end
        end
    end

    // Reference model state
    logic        dbits[256];
    logic [7:0]  corr[4];
    logic        tx[$];
    logic [31:0] exp_words[$];
    logic        exp_blk[$];
    logic        exp_ok;
    int          last_cyc, q_cyc;
    int          n_pass = 0, n_total = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Remainder of M(x)*x^7 divided by x^7+x^6+x^5+x^2+1
    function automatic logic [6:0] crc_ref(input int start, input int n);
        logic [7:0] rem = 8'd0;
        for (int i = 0; i < n + 7; i++) begin
            rem = {rem[6:0], (i < n) ? dbits[start + i] : 1'b0};
            if (rem[7]) rem = rem ^ 8'hE5;
        end
        return rem[6:0];
    endfunction

    task automatic build(input int sel);
        int len, blen, ones;
        logic [6:0] crc;
        logic [7:0] chk;
        logic [15:0] w;
        len = 16 << sel;
        tx.delete(); exp_words.delete(); exp_blk.delete();
        exp_ok = 1'b1;
        for (int b = 0; b * 64 < len; b++) begin
            blen = (len - b * 64 > 64) ? 64 : len - b * 64;
            crc  = crc_ref(b * 64, blen);
            ones = $countones(crc);
            for (int i = 0; i < blen; i++) begin
                tx.push_back(dbits[b * 64 + i]);
                ones += int'(dbits[b * 64 + i]);
            end
            chk = {crc, ones[0]} ^ corr[b];
            for (int j = 7; j >= 0; j--) tx.push_back(chk[j]);
            exp_blk.push_back(corr[b] != 8'd0);
            if (corr[b] != 8'd0) exp_ok = 1'b0;
        end
        for (int k = 0; k < len / 16; k++) begin
            for (int i = 0; i < 16; i++) w[15 - i] = dbits[k * 16 + i];
            exp_words.push_back({11'd0, 5'(k), w});
        end
    endtask

    task automatic send(input int sel, input bit gap, input int q_at, input int stop_at);
        for (int i = 0; i < tx.size(); i++) begin
            if (i == stop_at) break;
            @(negedge clk_3M);
            frame_start = (i == 0); bit_valid = 1'b1; data_in = tx[i];
            quality_error = (i == q_at); frame_len_sel = 3'(sel);
            if (i == q_at) q_cyc = cyc;
            last_cyc = cyc;
            if (gap) begin
                @(negedge clk_3M);
                frame_start = 1'b0; bit_valid = 1'b0; quality_error = 1'b0;
            end
        end
        @(negedge clk_3M);
        frame_start = 1'b0; bit_valid = 1'b0; quality_error = 1'b0; data_in = 1'b0;
    endtask

    task automatic clear_mon();
        mon_words.delete(); mon_blk.delete(); mon_frm.delete();
        mon_abort = 0; fd_cyc = -1; ab_cyc = -1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk_3M);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 256; i++) dbits[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic zero_setup();
        for (int i = 0; i < 256; i++) dbits[i] = 1'b0;
        for (int b = 0; b < 4; b++) corr[b] = 8'd0;
    endtask

    task automatic check_frame(input string tag, input int exp_abort, input bit chk_lat);
        check({tag, "_nwords"}, 64'(mon_words.size()), 64'(exp_words.size()));
        for (int i = 0; i < exp_words.size(); i++)
            check($sformatf("%s_word%0d", tag, i),
                  (i < mon_words.size()) ? 64'(mon_words[i]) : 64'hX, 64'(exp_words[i]));
        check({tag, "_nblk"}, 64'(mon_blk.size()), 64'(exp_blk.size()));
        for (int i = 0; i < exp_blk.size(); i++)
            check($sformatf("%s_crcerr%0d", tag, i),
                  (i < mon_blk.size()) ? 64'(mon_blk[i]) : 64'hX, 64'(exp_blk[i]));
        check({tag, "_nframe"}, 64'(mon_frm.size()), 64'd1);
        check({tag, "_frame_ok"}, (mon_frm.size() > 0) ? 64'(mon_frm[0]) : 64'hX, 64'(exp_ok));
        check({tag, "_aborts"}, 64'(mon_abort), 64'(exp_abort));
        if (chk_lat) check({tag, "_done_lat"}, 64'(fd_cyc), 64'(last_cyc + 1));
    endtask

    function automatic logic [27:0] all_outs();
        return {word_data, word_valid, word_index, block_done, crc_error,
                frame_done, frame_ok, frame_abort, busy};
    endfunction

    initial begin
        clear_mon();
        repeat (3) @(negedge clk_3M);
        #1;
        check("reset_outputs", 64'(all_outs()), 64'd0);
        @(negedge clk_3M);
        rst = 1'b1;
        @(negedge clk_3M);

        // 16-bit zero frame, correct and corrupted check
        zero_setup(); build(0); clear_mon(); send(0, 1'b0, -1, -1); settle();
        check_frame("f16_ok", 0, 1'b1);
        zero_setup(); corr[0] = 8'h01; build(0); clear_mon(); send(0, 1'b0, -1, -1); settle();
        check_frame("f16_bad", 0, 1'b1);

        // 256-bit zero frame
        zero_setup(); build(4); clear_mon(); send(4, 1'b0, -1, -1); settle();
        check_frame("f256_zero", 0, 1'b1);

        // 128-bit random frame, block 0 check corrupted
        zero_setup(); rand_data(); corr[0] = 8'($urandom_range(1, 255));
        build(3); clear_mon(); send(3, 1'b0, -1, -1); settle();
        check_frame("f128_blk0bad", 0, 1'b1);

        // Quality error on bit 20 of a 64-bit frame
        zero_setup(); rand_data(); build(2); clear_mon(); send(2, 1'b0, 20, -1); settle();
        check("qerr_nwords", 64'(mon_words.size()), 64'd1);
        check("qerr_word0", (mon_words.size() > 0) ? 64'(mon_words[0]) : 64'hX, 64'(exp_words[0]));
        check("qerr_nblk", 64'(mon_blk.size()), 64'd0);
        check("qerr_nframe", 64'(mon_frm.size()), 64'd0);
        check("qerr_aborts", 64'(mon_abort), 64'd1);
        check("qerr_abort_lat", 64'(ab_cyc), 64'(q_cyc + 1));
        check("qerr_busy", 64'(busy), 64'd0);

        // Reserved length selection
        clear_mon();
        @(negedge clk_3M);
        frame_start = 1'b1; bit_valid = 1'b1; data_in = 1'b1; frame_len_sel = 3'd5;
        @(negedge clk_3M);
        frame_start = 1'b0; bit_valid = 1'b0;
        settle();
        check("rsv_aborts", 64'(mon_abort), 64'd1);
        check("rsv_busy", 64'(busy), 64'd0);
        check("rsv_nwords", 64'(mon_words.size()), 64'd0);

        // Asynchronous reset at bit 40 of a gapped 64-bit frame
        zero_setup(); rand_data(); build(2); clear_mon(); send(2, 1'b1, -1, 41);
        check("rst_pre_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1 check("rst_async_outputs", 64'(all_outs()), 64'd0);
        repeat (2) @(negedge clk_3M);
        rst = 1'b1;
        @(negedge clk_3M);
        zero_setup(); rand_data(); build(2); clear_mon(); send(2, 1'b1, -1, -1); settle();
        check_frame("rst_next_frame", 0, 1'b1);

        // New frame_start while busy abandons the old frame
        zero_setup(); rand_data(); build(1); clear_mon(); send(1, 1'b0, -1, 10);
        rand_data(); build(0); send(0, 1'b0, -1, -1); settle();
        check_frame("restart", 1, 1'b1);

        // Randomized frames
        for (int k = 0; k < 6; k++) begin
            int sel;
            bit gap;
            sel = int'($urandom_range(0, 4));
            gap = 1'($urandom_range(0, 1));
            rand_data();
            for (int b = 0; b < 4; b++)
                corr[b] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
            build(sel); clear_mon(); send(sel, gap, -1, -1); settle();
            check_frame($sformatf("rand%0d", k), 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
